// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller beside decode: load-use bubble insertion,
// multi-cycle mult/div sequencing, redirect qualification and stall counting.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT    = 4,
  parameter int DIV_LAT    = 32,
  parameter int DELAY_SLOT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regaRd,
  input  logic        regbRd,
  input  logic [4:0]  regaAddr,
  input  logic [4:0]  regbAddr,
  input  logic        jCe,
  input  logic        md_start,
  input  logic        md_div,
  input  logic        ex_memRd,
  input  logic        ex_regcWr,
  input  logic [4:0]  ex_regcAddr,
  input  logic        cnt_clr,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_flush,
  output logic        if_id_flush,
  output logic        jce_o,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // The acceptance cycle is busy cycle 1, so MD_BUSY spans L-1 cycles ending at lat_cnt==0.
  localparam logic [31:0] MUL_LOAD = 32'(MUL_LAT - 2);
  localparam logic [31:0] DIV_LOAD = 32'(DIV_LAT - 2);

  state_t      state, state_nxt;
  logic [31:0] lat_cnt, lat_cnt_nxt;
  logic [31:0] stall_cnt_q, stall_cnt_nxt;
  logic        hazard;
  logic        accept;
  logic        busy;
  logic        stall;

  assign hazard = ex_memRd & ex_regcWr & (ex_regcAddr != 5'd0) &
                  ((regaRd & (regaAddr == ex_regcAddr)) |
                   (regbRd & (regbAddr == ex_regcAddr)));

  assign busy   = (state == MD_BUSY);
  assign accept = ~busy & ~hazard & md_start;
  assign stall  = ~rst & (busy | hazard | accept);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    case (state)
      RUN: begin
        if (accept) begin
          state_nxt   = MD_BUSY;
          lat_cnt_nxt = md_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      MD_BUSY: begin
        if (lat_cnt == 32'd0) begin
          state_nxt = RUN;
        end else begin
          lat_cnt_nxt = lat_cnt - 32'd1;
        end
      end
      default: begin
        state_nxt   = RUN;
        lat_cnt_nxt = '0;
      end
    endcase
  end

  // Redirects are only honoured when nothing holds the front end, so a flush never meets a stall.
  always_comb begin
    pc_stall    = stall;
    if_id_stall = stall;
    id_ex_flush = stall;
    md_busy     = ~rst & (busy | accept);
    md_done     = ~rst & busy & (lat_cnt == 32'd0);
    jce_o       = ~rst & ~stall & jCe;
    if_id_flush = ~rst & ~stall & jCe & (DELAY_SLOT == 0);
  end

  // Written every cycle so the next value is always derived from the visible count.
  always_comb begin
    stall_cnt_nxt = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_nxt = '0;
    end else if (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_nxt = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_nxt;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; a second instance with
// DELAY_SLOT=0 shares all inputs to check the IF/ID flush on redirect.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        regaRd, regbRd;
  logic [4:0]  regaAddr, regbAddr;
  logic        jCe, md_start, md_div;
  logic        ex_memRd, ex_regcWr;
  logic [4:0]  ex_regcAddr;
  logic        cnt_clr;

  logic        pc_stall, if_id_stall, id_ex_flush, if_id_flush, jce_o;
  logic        md_busy, md_done;
  logic [31:0] stall_cnt;

  logic        pc_stall0, if_id_stall0, id_ex_flush0, if_id_flush0, jce_o0;
  logic        md_busy0, md_done0;
  logic [31:0] stall_cnt0;

  int tests;
  int fails;

  pipe_hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .DELAY_SLOT(1)) dut (
    .clk(clk), .rst(rst),
    .regaRd(regaRd), .regbRd(regbRd), .regaAddr(regaAddr), .regbAddr(regbAddr),
    .jCe(jCe), .md_start(md_start), .md_div(md_div),
    .ex_memRd(ex_memRd), .ex_regcWr(ex_regcWr), .ex_regcAddr(ex_regcAddr),
    .cnt_clr(cnt_clr),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_flush(id_ex_flush),
    .if_id_flush(if_id_flush), .jce_o(jce_o),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .DELAY_SLOT(0)) dut0 (
    .clk(clk), .rst(rst),
    .regaRd(regaRd), .regbRd(regbRd), .regaAddr(regaAddr), .regbAddr(regbAddr),
    .jCe(jCe), .md_start(md_start), .md_div(md_div),
    .ex_memRd(ex_memRd), .ex_regcWr(ex_regcWr), .ex_regcAddr(ex_regcAddr),
    .cnt_clr(cnt_clr),
    .pc_stall(pc_stall0), .if_id_stall(if_id_stall0), .id_ex_flush(id_ex_flush0),
    .if_id_flush(if_id_flush0), .jce_o(jce_o0),
    .md_busy(md_busy0), .md_done(md_done0), .stall_cnt(stall_cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after a falling edge; checks follow 1ns later, well before the rising edge.
  task idle_inputs;
    regaRd = 0; regbRd = 0; regaAddr = 0; regbAddr = 0;
    jCe = 0; md_start = 0; md_div = 0;
    ex_memRd = 0; ex_regcWr = 0; ex_regcAddr = 0; cnt_clr = 0;
  endtask

  task clear_counter;
    @(negedge clk);
    idle_inputs();
    cnt_clr = 1;
    @(negedge clk);
    cnt_clr = 0;
  endtask

  task set_hazard_a(input logic [4:0] dst);
    ex_memRd = 1; ex_regcWr = 1; ex_regcAddr = dst;
    regaRd = 1; regaAddr = dst;
  endtask

  task test_reset;
    rst = 1;
    idle_inputs();
    #12;
    tests++;
    if ({pc_stall, if_id_stall, id_ex_flush, if_id_flush, jce_o, md_busy, md_done} !== 7'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs got %b want 0000000",
               {pc_stall, if_id_stall, id_ex_flush, if_id_flush, jce_o, md_busy, md_done});
    end
    tests++;
    if (stall_cnt !== 32'd0) begin
      fails++;
      $display("[TB] FAIL reset_stall_cnt got %h want 00000000", stall_cnt);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task test_load_use;
    clear_counter();
    set_hazard_a(5'd5);
    #1;
    tests++;
    if ({pc_stall, if_id_stall, id_ex_flush, if_id_flush} !== 4'b1110) begin
      fails++;
      $display("[TB] FAIL load_use_rs got %b want 1110", {pc_stall, if_id_stall, id_ex_flush, if_id_flush});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    tests++;
    if (stall_cnt !== 32'd1 || pc_stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL load_use_count got cnt=%0d stall=%b want cnt=1 stall=0", stall_cnt, pc_stall);
    end
    @(negedge clk);
    ex_memRd = 1; ex_regcWr = 1; ex_regcAddr = 5'd9; regbRd = 1; regbAddr = 5'd9;
    regaRd = 1; regaAddr = 5'd3;
    #1;
    tests++;
    if (pc_stall !== 1'b1) begin
      fails++;
      $display("[TB] FAIL load_use_rt got %b want 1", pc_stall);
    end
    @(negedge clk);
    idle_inputs();
    set_hazard_a(5'd0);
    regbRd = 1;
    #1;
    tests++;
    if (pc_stall !== 1'b0 || id_ex_flush !== 1'b0) begin
      fails++;
      $display("[TB] FAIL load_use_r0 got %b%b want 00", pc_stall, id_ex_flush);
    end
    @(negedge clk);
    idle_inputs();
    ex_memRd = 0; ex_regcWr = 1; ex_regcAddr = 5'd7; regaRd = 1; regaAddr = 5'd7;
    #1;
    tests++;
    if (pc_stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL no_load_no_stall got %b want 0", pc_stall);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task run_md(input logic is_div, input int lat, input string name);
    clear_counter();
    md_start = 1;
    md_div   = is_div;
    for (int i = 0; i < lat; i++) begin
      if (i > 0) begin
        @(negedge clk);
        md_start = 0;
        md_div   = 0;
        jCe      = (i == 2);
      end
      #1;
      tests++;
      if ({pc_stall, if_id_stall, id_ex_flush, md_busy, md_done, jce_o} !==
          {5'b11110 | {4'b0, (i == lat - 1)}, 1'b0}) begin
        fails++;
        $display("[TB] FAIL %s_cycle%0d got stl/ifs/fl/busy/done/jce=%b want %b", name, i,
                 {pc_stall, if_id_stall, id_ex_flush, md_busy, md_done, jce_o},
                 {5'b11110 | {4'b0, (i == lat - 1)}, 1'b0});
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    tests++;
    if (pc_stall !== 1'b0 || md_busy !== 1'b0 || md_done !== 1'b0 || stall_cnt !== 32'(lat)) begin
      fails++;
      $display("[TB] FAIL %s_end got stall=%b busy=%b done=%b cnt=%0d want 0 0 0 %0d",
               name, pc_stall, md_busy, md_done, stall_cnt, lat);
    end
  endtask

  task test_multiply;
    run_md(1'b0, 4, "mul");
  endtask

  task test_divide;
    run_md(1'b1, 32, "div");
  endtask

  task test_hazard_priority;
    @(negedge clk);
    idle_inputs();
    set_hazard_a(5'd12);
    jCe = 1; md_start = 1;
    #1;
    tests++;
    if (jce_o !== 1'b0 || pc_stall !== 1'b1 || md_busy !== 1'b0 || if_id_flush0 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL hazard_prio got jce=%b stall=%b busy=%b flush0=%b want 0 1 0 0",
               jce_o, pc_stall, md_busy, if_id_flush0);
    end
    @(negedge clk);
    idle_inputs();
    md_start = 1;
    #1;
    tests++;
    if (md_busy !== 1'b1 || pc_stall !== 1'b1) begin
      fails++;
      $display("[TB] FAIL hazard_then_md got busy=%b stall=%b want 1 1", md_busy, pc_stall);
    end
    @(negedge clk);
    md_start = 0;
    #1;
    tests++;
    if (md_busy !== 1'b1 || md_done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL md_entered got busy=%b done=%b want 1 0", md_busy, md_done);
    end
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (md_busy !== 1'b0 || pc_stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL md_drained got busy=%b stall=%b want 0 0", md_busy, pc_stall);
    end
  endtask

  task test_redirect;
    @(negedge clk);
    idle_inputs();
    jCe = 1;
    #1;
    tests++;
    if (jce_o !== 1'b1 || if_id_flush !== 1'b0 || pc_stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL redirect_ds1 got jce=%b flush=%b stall=%b want 1 0 0", jce_o, if_id_flush, pc_stall);
    end
    tests++;
    if (jce_o0 !== 1'b1 || if_id_flush0 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL redirect_ds0 got jce=%b flush=%b want 1 1", jce_o0, if_id_flush0);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task test_reset_mid_divide;
    @(negedge clk);
    idle_inputs();
    md_start = 1; md_div = 1;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      md_start = 0; md_div = 0;
    end
    #1;
    rst = 1;
    #1;
    tests++;
    if ({pc_stall, if_id_stall, id_ex_flush, if_id_flush, jce_o, md_busy, md_done} !== 7'b0 ||
        stall_cnt !== 32'd0) begin
      fails++;
      $display("[TB] FAIL reset_mid_div got %b cnt=%0d want 0000000 cnt=0",
               {pc_stall, if_id_stall, id_ex_flush, if_id_flush, jce_o, md_busy, md_done}, stall_cnt);
    end
    @(negedge clk);
    rst = 0;
    jCe = 1;
    #1;
    tests++;
    if (md_busy !== 1'b0 || md_done !== 1'b0 || pc_stall !== 1'b0 || jce_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL after_reset_run got busy=%b done=%b stall=%b jce=%b want 0 0 0 1",
               md_busy, md_done, pc_stall, jce_o);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task test_saturation;
    @(negedge clk);
    idle_inputs();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.stall_cnt_q;
    set_hazard_a(5'd4);
    repeat (3) @(negedge clk);
    idle_inputs();
    #1;
    tests++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      fails++;
      $display("[TB] FAIL stall_cnt_saturate got %h want ffffffff", stall_cnt);
    end
    set_hazard_a(5'd4);
    cnt_clr = 1;
    @(negedge clk);
    idle_inputs();
    #1;
    tests++;
    if (stall_cnt !== 32'd0) begin
      fails++;
      $display("[TB] FAIL clr_over_stall got %h want 00000000", stall_cnt);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_load_use();
    test_multiply();
    test_divide();
    test_hazard_priority();
    test_redirect();
    test_reset_mid_divide();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
